// File: rtl/pwm_olu_zaman_uretici.sv
// Dead-time generator: turns one PWM line into a complementary high/low gate pair
// with programmable dead time, suppressing (and counting) pulses shorter than it.
//
// state  | meaning
// KAPALI | disabled, both gates off
// OLU_Y  | dead interval before high-side conduction
// YUKSEK | high-side conducting
// OLU_A  | dead interval before low-side conduction
// ALCAK  | low-side conducting
module pwm_olu_zaman_uretici #(
   parameter int OLU_ZAMAN_GEN = 16,
   parameter int SAYAC_GEN     = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     etkin_i,
   input  logic                     pwm_i,
   input  logic [OLU_ZAMAN_GEN-1:0] olu_zaman_i,
   input  logic                     sayac_temizle_i,
   output logic                     yuksek_o,
   output logic                     alcak_o,
   output logic                     bastirma_o,
   output logic [SAYAC_GEN-1:0]     bastirma_sayisi_o
);

   typedef enum logic [2:0] {KAPALI, OLU_Y, YUKSEK, OLU_A, ALCAK} durum_t;

   localparam logic [OLU_ZAMAN_GEN-1:0] ZAMAN_BIR = OLU_ZAMAN_GEN'(1);
   localparam logic [SAYAC_GEN-1:0]     SAYI_BIR  = SAYAC_GEN'(1);

   durum_t                   durum_q, durum_d;
   logic                     pwm_q;
   logic [OLU_ZAMAN_GEN-1:0] sayac_q, sayac_d;
   logic                     ilk_q, ilk_d;
   logic                     bastir_d;
   logic                     yuksek_d, alcak_d;
   logic [SAYAC_GEN-1:0]     sayi_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         durum_q           <= KAPALI;
         pwm_q             <= 1'b0;
         sayac_q           <= '0;
         ilk_q             <= 1'b0;
         yuksek_o          <= 1'b0;
         alcak_o           <= 1'b0;
         bastirma_o        <= 1'b0;
         bastirma_sayisi_o <= '0;
      end else begin
         durum_q           <= durum_d;
         pwm_q             <= pwm_i;
         sayac_q           <= sayac_d;
         ilk_q             <= ilk_d;
         yuksek_o          <= yuksek_d;
         alcak_o           <= alcak_d;
         bastirma_o        <= bastir_d;
         bastirma_sayisi_o <= sayi_d;
      end
   end

   // ilk_q marks a dead interval entered from KAPALI: no switch has conducted yet,
   // so a level reversal there retargets the other dead state instead of aborting.
   always_comb begin
      durum_d  = durum_q;
      sayac_d  = sayac_q;
      ilk_d    = ilk_q;
      bastir_d = 1'b0;
      if (!etkin_i) begin
         durum_d = KAPALI;
         sayac_d = '0;
         ilk_d   = 1'b0;
      end else begin
         case (durum_q)
            KAPALI: begin
               durum_d = pwm_q ? OLU_Y : OLU_A;
               sayac_d = olu_zaman_i;
               ilk_d   = 1'b1;
            end
            ALCAK: begin
               if (pwm_q) begin
                  ilk_d = 1'b0;
                  if (olu_zaman_i == '0) begin
                     durum_d = YUKSEK;
                  end else begin
                     durum_d = OLU_Y;
                     sayac_d = olu_zaman_i;
                  end
               end
            end
            YUKSEK: begin
               if (!pwm_q) begin
                  ilk_d = 1'b0;
                  if (olu_zaman_i == '0) begin
                     durum_d = ALCAK;
                  end else begin
                     durum_d = OLU_A;
                     sayac_d = olu_zaman_i;
                  end
               end
            end
            OLU_Y: begin
               if (!pwm_q) begin
                  if (ilk_q) begin
                     durum_d = OLU_A;
                     sayac_d = olu_zaman_i;
                  end else begin
                     durum_d  = ALCAK;
                     sayac_d  = '0;
                     bastir_d = 1'b1;
                  end
               end else if (sayac_q <= ZAMAN_BIR) begin
                  durum_d = YUKSEK;
                  sayac_d = '0;
                  ilk_d   = 1'b0;
               end else begin
                  sayac_d = sayac_q - ZAMAN_BIR;
               end
            end
            OLU_A: begin
               if (pwm_q) begin
                  if (ilk_q) begin
                     durum_d = OLU_Y;
                     sayac_d = olu_zaman_i;
                  end else begin
                     durum_d  = YUKSEK;
                     sayac_d  = '0;
                     bastir_d = 1'b1;
                  end
               end else if (sayac_q <= ZAMAN_BIR) begin
                  durum_d = ALCAK;
                  sayac_d = '0;
                  ilk_d   = 1'b0;
               end else begin
                  sayac_d = sayac_q - ZAMAN_BIR;
               end
            end
            default: begin
               durum_d = KAPALI;
               sayac_d = '0;
               ilk_d   = 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      yuksek_d = (durum_d == YUKSEK);
      alcak_d  = (durum_d == ALCAK);
      sayi_d   = bastirma_sayisi_o;
      if (sayac_temizle_i) begin
         sayi_d = bastir_d ? SAYI_BIR : '0;
      end else if (bastir_d && (bastirma_sayisi_o != '1)) begin
         sayi_d = bastirma_sayisi_o + SAYI_BIR;
      end
   end

endmodule
